// File: rtl/instr_sequencer.sv
// instr_sequencer: multicycle fetch/decode/execute/writeback control for ADDI and JAL.
// Owns the architectural PC. Optional trap redirect on illegal instructions is
// compiled in with `define SEQ_TRAP_EN; the default build halts instead.

package Instruction;
  typedef enum logic [1:0] {INSTR_ADDI, INSTR_JAL, INSTR_ILLEGAL} InstrType;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } I_Type;

  typedef struct packed {
    logic        imm20;
    logic [9:0]  imm10_1;
    logic        imm11;
    logic [7:0]  imm19_12;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } J_Type;

  typedef struct packed {
    InstrType    kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
  } Instr;
endpackage

module instr_sequencer
  import Instruction::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [4:0]  rf_rs1_addr,
  input  logic [31:0] rf_rs1_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        illegal,
  output logic        halted,
  output logic [31:0] trap_epc
);

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [2:0] {FETCH_REQ, FETCH_WAIT, EXEC, WB, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] result_q, result_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [4:0]  rd_q, rd_d;
  logic        legal_q, legal_d;
  logic        req_sticky_q, req_sticky_d;

  I_Type       iw;
  J_Type       jw;
  Instr        dec;
  logic [31:0] exec_result;
  logic [31:0] exec_next_pc;
  logic        exec_legal;

`ifdef SEQ_TRAP_EN
  logic [31:0] trap_epc_q, trap_epc_d;
`else
  logic        unused_trap_pc;
  assign unused_trap_pc = ^TRAP_PC;
`endif

  // State and datapath registers, all returning to reset values asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH_REQ;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      result_q     <= '0;
      next_pc_q    <= '0;
      rd_q         <= '0;
      legal_q      <= 1'b0;
      req_sticky_q <= 1'b0;
`ifdef SEQ_TRAP_EN
      trap_epc_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      result_q     <= result_d;
      next_pc_q    <= next_pc_d;
      rd_q         <= rd_d;
      legal_q      <= legal_d;
      req_sticky_q <= req_sticky_d;
`ifdef SEQ_TRAP_EN
      trap_epc_q   <= trap_epc_d;
`endif
    end
  end

  // Split the instruction register into ADDI/JAL fields and rebuild the immediate
  always_comb begin
    iw       = I_Type'(ir_q);
    jw       = J_Type'(ir_q);
    dec.kind = INSTR_ILLEGAL;
    dec.rd   = iw.rd;
    dec.rs1  = iw.rs1;
    dec.imm  = '0;
    if (iw.opcode == OP_ADDI && iw.funct3 == 3'b000) begin
      dec.kind = INSTR_ADDI;
      dec.imm  = {{20{iw.imm[11]}}, iw.imm};
    end else if (jw.opcode == OP_JAL) begin
      dec.kind = INSTR_JAL;
      dec.rd   = jw.rd;
      dec.imm  = {{11{jw.imm20}}, jw.imm20, jw.imm19_12, jw.imm11, jw.imm10_1, 1'b0};
    end
  end

  // Result, successor PC and legality; a JAL landing on a non-word address is illegal
  always_comb begin
    exec_result  = '0;
    exec_next_pc = pc_q + 32'd4;
    exec_legal   = 1'b0;
    unique case (dec.kind)
      INSTR_ADDI: begin
        exec_result = rf_rs1_data + dec.imm;
        exec_legal  = 1'b1;
      end
      INSTR_JAL: begin
        exec_result  = pc_q + 32'd4;
        exec_next_pc = pc_q + dec.imm;
        exec_legal   = ~exec_next_pc[1];
      end
      default: ;
    endcase
  end

  // Next-state logic; the request stays pending via req_sticky once raised
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    result_d     = result_q;
    next_pc_d    = next_pc_q;
    rd_d         = rd_q;
    legal_d      = legal_q;
    req_sticky_d = req_sticky_q;
`ifdef SEQ_TRAP_EN
    trap_epc_d   = trap_epc_q;
`endif
    unique case (state_q)
      FETCH_REQ: begin
        if (imem_req_valid) begin
          if (imem_req_ready) begin
            req_sticky_d = 1'b0;
            state_d      = FETCH_WAIT;
          end else begin
            req_sticky_d = 1'b1;
          end
        end
      end
      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          ir_d    = imem_resp_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d  = exec_result;
        next_pc_d = exec_next_pc;
        rd_d      = dec.rd;
        legal_d   = exec_legal;
        state_d   = WB;
      end
      WB: begin
        if (legal_q) begin
          pc_d    = next_pc_q;
          state_d = FETCH_REQ;
        end else begin
`ifdef SEQ_TRAP_EN
          trap_epc_d = pc_q;
          pc_d       = TRAP_PC;
          state_d    = FETCH_REQ;
`else
          state_d    = HALT;
`endif
        end
      end
      HALT: state_d = HALT;
      default: state_d = FETCH_REQ;
    endcase
  end

  // Outputs decoded from the current state and registered datapath values
  always_comb begin
    imem_req_valid = (state_q == FETCH_REQ) && (run || req_sticky_q);
    rf_we          = (state_q == WB) && legal_q && (rd_q != 5'd0);
    retire         = (state_q == WB) && legal_q;
`ifdef SEQ_TRAP_EN
    illegal        = (state_q == WB) && !legal_q;
    halted         = 1'b0;
    trap_epc       = trap_epc_q;
`else
    illegal        = (state_q == HALT);
    halted         = (state_q == HALT);
    trap_epc       = '0;
`endif
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign rf_rs1_addr = dec.rs1;
  assign rf_waddr    = rd_q;
  assign rf_wdata    = result_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized memory/handshake stimulus with a scoreboard fed by
// an architectural reference model (register array + PC) of ADDI/JAL execution.
module tb_instr_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

  logic        clk, rst, run;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_addr, imem_resp_data;
  logic [4:0]  rf_rs1_addr, rf_waddr;
  logic [31:0] rf_rs1_data, rf_wdata, pc, trap_epc;
  logic        rf_we, retire, illegal, halted;

  instr_sequencer #(.RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .rf_rs1_addr(rf_rs1_addr),
    .rf_rs1_data(rf_rs1_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .pc(pc), .retire(retire), .illegal(illegal),
    .halted(halted), .trap_epc(trap_epc)
  );

  typedef struct {
    logic [31:0] addr;
    logic        ill;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          lat;
    int          start;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] forced_q[$];
  int          stall_q[$];
  int          delay_q[$];
  logic [31:0] model_rf[32];
  logic [31:0] env_rf[32];
  logic [31:0] model_pc;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          retire_count = 0;
  int          accept_count = 0;
  int          run_mode = 0;
  bit          rand_timing = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] seed_val(input int i);
    return (i == 0) ? 32'd0 : (32'h0101_0101 * i) ^ 32'hA5A5_0000;
  endfunction

  // Environment register file: combinational read, written by the DUT strobe
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 32; i++) env_rf[i] <= seed_val(i);
    end else if (rf_we && rf_waddr != 5'd0) begin
      env_rf[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rs1_data = env_rf[rf_rs1_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word, input int stall, input int delay);
    forced_q.push_back(word);
    stall_q.push_back(stall);
    delay_q.push_back(delay);
  endtask

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] random_word();
    int o;
    logic [20:0] off;
    if ($urandom_range(0, 9) < 6)
      return enc_addi(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 12'($urandom));
    o   = (int'($urandom_range(0, 1023)) - 512) * 4;
    off = o[20:0];
    return enc_jal(5'($urandom_range(0, 31)), off);
  endfunction

  // Architectural reference: what executing word at addr should do
  task automatic model_step(input logic [31:0] addr, input logic [31:0] w, output exp_t e);
    int          ai, j;
    logic [31:0] tgt;
    e.addr = addr; e.waddr = w[11:7]; e.ill = 1'b1; e.we = 1'b0;
    e.wdata = '0; e.lat = 0; e.start = 0;
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
      ai = $signed(w) >>> 20;
      e.wdata = model_rf[w[19:15]] + ai;
      e.ill = 1'b0;
      model_pc = addr + 32'd4;
    end else if (w[6:0] == 7'h6F) begin
      j = (w[31] ? -1048576 : 0) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
      tgt = addr + j;
      e.wdata = addr + 32'd4;
      e.ill = tgt[1];
      if (!e.ill) model_pc = tgt;
    end
    if (!e.ill) begin
      e.we = (e.waddr != 5'd0);
    end else begin
`ifdef SEQ_TRAP_EN
      model_pc = TRAP_PC;
`else
      model_pc = addr;
`endif
    end
  endtask

  // Memory responder: drives run/ready/response and pushes expectations at acceptance
  initial begin
    bit          req_open = 0;
    bit          pending = 0;
    int          stall_left = 0, cur_stall = 0, cur_delay = 0, cur_start = 0, countdown = 0;
    logic [31:0] pend_word = '0, prev_addr = '0, word;
    exp_t        e;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; run = 1'b0;
    forever begin
      @(negedge clk);
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (pending) begin
        if (countdown == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = pend_word;
          pending = 0;
        end else begin
          countdown--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        imem_resp_valid = 1'b1;
      end
      run = (run_mode == 2) ? ($urandom_range(0, 3) != 0) : (run_mode == 1);
      #1;
      if (rst) begin
        imem_req_ready = 1'b0;
        req_open = 0;
      end else if (imem_req_valid) begin
        if (!req_open) begin
          req_open   = 1;
          cur_start  = cyc;
          stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : (rand_timing ? int'($urandom_range(0, 3)) : 0);
          cur_delay  = (delay_q.size() > 0) ? delay_q.pop_front() : (rand_timing ? int'($urandom_range(0, 3)) : 0);
          cur_stall  = stall_left;
          checkOutput("fetch_addr", imem_addr, model_pc);
        end else begin
          checkOutput("req_addr_stable", imem_addr, prev_addr);
        end
        prev_addr = imem_addr;
        if (stall_left > 0) begin
          imem_req_ready = 1'b0;
          stall_left--;
        end else begin
          imem_req_ready = 1'b1;
          word = (forced_q.size() > 0) ? forced_q.pop_front() : random_word();
          model_step(model_pc, word, e);
          e.start = cur_start;
          e.lat   = 4 + cur_stall + cur_delay;
          sb.push_back(e);
          pending   = 1;
          countdown = cur_delay;
          pend_word = word;
          req_open  = 0;
          accept_count++;
        end
      end else begin
        if (req_open) checkOutput("req_valid_held", {31'd0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops an expectation whenever an instruction completes or faults
  initial begin
    logic ill_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ill_prev = 1'b0;
      end else begin
        if (rf_we && !retire) checkOutput("stray_rf_we", {31'd0, rf_we}, 32'd0);
        if (retire || (illegal && !ill_prev)) begin
          if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("[TB] FAIL sb_underflow actual=completion required=none pc=0x%08h", pc);
          end else begin
            e = sb.pop_front();
            checkOutput("event_pc", pc, e.addr);
            checkOutput("illegal_flag", {31'd0, illegal}, {31'd0, e.ill});
            checkOutput("retire_flag", {31'd0, retire}, {31'd0, !e.ill});
            if (!e.ill) begin
              checkOutput("rf_we", {31'd0, rf_we}, {31'd0, e.we});
              if (e.we) begin
                checkOutput("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
                checkOutput("rf_wdata", rf_wdata, e.wdata);
                model_rf[e.waddr] = e.wdata;
              end
              checkOutput("latency", cyc - e.start + 1, e.lat);
            end
            retire_count++;
          end
        end
        ill_prev = illegal;
      end
    end
  end

  task automatic wait_retires(input int target, input int budget);
    int n = 0;
    while (retire_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("retire_count_reached", {31'd0, retire_count >= target}, 32'd1);
  endtask

  initial begin
    int n, a0;
    rst = 1'b1;
    model_pc = RESET_PC;
    for (int i = 0; i < 32; i++) model_rf[i] = seed_val(i);
    repeat (3) @(negedge clk);
    checkOutput("reset_pc", pc, RESET_PC);
    checkOutput("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("reset_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("reset_retire", {31'd0, retire}, 32'd0);
    checkOutput("reset_illegal", {31'd0, illegal}, 32'd0);
    checkOutput("reset_halted", {31'd0, halted}, 32'd0);
    checkOutput("reset_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    checkOutput("reset_rf_wdata", rf_wdata, 32'd0);
    checkOutput("reset_trap_epc", trap_epc, 32'd0);
    checkOutput("reset_rs1_addr", {27'd0, rf_rs1_addr}, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_no_request", {31'd0, imem_req_valid}, 32'd0);
    end

    $display("[TB] directed: addi/jal/addi x0/ready stall");
    applyStimulus(32'h0050_0093, 0, 0);
    applyStimulus(enc_addi(5'd2, 5'd1, 12'd3), 0, 0);
    applyStimulus(32'h0100_00EF, 0, 0);
    applyStimulus(32'hFFF0_0013, 0, 0);
    applyStimulus(enc_addi(5'd3, 5'd1, 12'd7), 3, 0);
    run_mode = 1;
    wait_retires(4, 60);
    run_mode = 2;
    wait_retires(5, 60);

    $display("[TB] randomized traffic");
    rand_timing = 1;
    wait_retires(retire_count + 120, 6000);

    $display("[TB] reset during fetch wait");
    rand_timing = 0;
    run_mode = 1;
    wait_retires(retire_count + 1, 100);
    delay_q.push_back(6);
    stall_q.push_back(0);
    a0 = accept_count;
    n = 0;
    while (accept_count == a0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reset_test_accept", {31'd0, accept_count != a0}, 32'd1);
    rst = 1'b1;
    run_mode = 0;
    sb.delete();
    model_pc = RESET_PC;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checkOutput("post_reset_pc", pc, RESET_PC);
      checkOutput("post_reset_no_we", {31'd0, rf_we}, 32'd0);
      checkOutput("post_reset_no_retire", {31'd0, retire}, 32'd0);
    end

    $display("[TB] illegal instruction at 0x20");
    applyStimulus(enc_jal(5'd0, 21'd32), 0, 0);
    applyStimulus(32'hFFFF_FFFF, 0, 0);
`ifdef SEQ_TRAP_EN
    applyStimulus(enc_addi(5'd5, 5'd0, 12'd9), 0, 0);
`endif
    run_mode = 1;
    n = 0;
    while (!illegal && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("illegal_seen", {31'd0, illegal}, 32'd1);
`ifdef SEQ_TRAP_EN
    a0 = retire_count;
    @(negedge clk);
    checkOutput("illegal_pulse_end", {31'd0, illegal}, 32'd0);
    checkOutput("trap_no_halt", {31'd0, halted}, 32'd0);
    checkOutput("trap_epc", trap_epc, 32'h20);
    wait_retires(a0 + 1, 100);
`else
    repeat (5) begin
      @(negedge clk);
      checkOutput("halt_halted", {31'd0, halted}, 32'd1);
      checkOutput("halt_illegal", {31'd0, illegal}, 32'd1);
      checkOutput("halt_pc", pc, 32'h20);
      checkOutput("halt_no_request", {31'd0, imem_req_valid}, 32'd0);
      checkOutput("halt_trap_epc", trap_epc, 32'd0);
    end
`endif
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
